cu_intr_ctrl: RTL and testbench

Parametrised interrupt controller for the pipelined processor control path. It supersedes the single `intr`/`Int_en` scheme with NUM_CH edge-detected interrupt channels, a per-channel mask, and fixed-priority arbitration. It also runs a request/acknowledge handshake with the fetch-stage CU. It sits beside the fetch CU: it drives `int_req` and `vec_addr`, and receives `int_ack` when the fetch stage injects the interrupt.

---
 rtl/cu_intr_ctrl.sv | 152 +++++++++++++++
 tb/tb_cu_intr_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cu_intr_ctrl.sv
`default_nettype none
// cu_intr_ctrl: edge-detected, masked, fixed-priority interrupt controller with a req/ack handshake to the fetch CU.
// Optional macro CU_INTR_SYNC_EN inserts a 2-flop synchronizer on every irq line ahead of edge detection.
module cu_intr_ctrl #(
   parameter int               NUM_CH   = 4,
   parameter int               VEC_W    = 8,
   parameter logic [VEC_W-1:0] VEC_BASE = 'h01
) (
   input  logic                                       clk,
   input  logic                                       rst,
   input  logic [NUM_CH-1:0]                          irq,
   input  logic                                       mask_we,
   input  logic [NUM_CH-1:0]                          mask_wdata,
   input  logic                                       ie_set,
   input  logic                                       ie_clr,
   input  logic                                       rti,
   input  logic                                       stall_in,
   input  logic                                       int_ack,
   output logic                                       int_req,
   output logic [VEC_W-1:0]                           vec_addr,
   output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] active_ch,
   output logic                                       in_service,
   output logic                                       int_en,
   output logic [NUM_CH-1:0]                          pending
);

   localparam int AW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      SERVICE = 2'd2
   } state_t;

   state_t            state_q;
   logic [NUM_CH-1:0] irq_s;
   logic [NUM_CH-1:0] irq_prev_q;
   logic [NUM_CH-1:0] pending_q;
   logic [NUM_CH-1:0] pending_d;
   logic [NUM_CH-1:0] mask_q;
   logic [NUM_CH-1:0] cand;
   logic [NUM_CH-1:0] clr;
   logic [AW-1:0]     win;
   logic [AW-1:0]     active_ch_q;
   logic [VEC_W-1:0]  vec_addr_q;
   logic              int_req_q;
   logic              in_service_q;
   logic              int_en_q;
   logic              int_en_d;
   logic              ack_fire;

`ifdef CU_INTR_SYNC_EN
   logic [NUM_CH-1:0] sync1_q;
   logic [NUM_CH-1:0] sync2_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= irq;
         sync2_q <= sync1_q;
      end
   end

   assign irq_s = sync2_q;
`else
   assign irq_s = irq;
`endif

   assign cand     = pending_q & mask_q;
   assign ack_fire = (state_q == REQ) && int_ack;

   // Descending scan so the lowest set index is the last (winning) assignment.
   always_comb begin
      win = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (cand[i]) win = AW'(i);
      end
   end

   always_comb begin
      clr = '0;
      if (ack_fire) clr = NUM_CH'(1) << active_ch_q;
      // A fresh edge landing on the ack cycle survives the clear.
      pending_d = (pending_q & ~clr) | (irq_s & ~irq_prev_q);
   end

   always_comb begin
      int_en_d = int_en_q;
      if (ie_set || ((state_q == SERVICE) && rti)) int_en_d = 1'b1;
      if (ie_clr || ack_fire)                      int_en_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         irq_prev_q   <= '0;
         pending_q    <= '0;
         mask_q       <= '1;
         int_en_q     <= 1'b0;
         int_req_q    <= 1'b0;
         in_service_q <= 1'b0;
         active_ch_q  <= '0;
         vec_addr_q   <= '0;
      end else begin
         irq_prev_q <= irq_s;
         pending_q  <= pending_d;
         int_en_q   <= int_en_d;
         if (mask_we) mask_q <= mask_wdata;

         case (state_q)
            IDLE: begin
               if (int_en_q && (|cand) && !stall_in) begin
                  state_q     <= REQ;
                  int_req_q   <= 1'b1;
                  active_ch_q <= win;
                  vec_addr_q  <= VEC_BASE + VEC_W'(win);
               end
            end
            REQ: begin
               // Grant is frozen here: no re-arbitration, stall is ignored.
               if (int_ack) begin
                  state_q      <= SERVICE;
                  int_req_q    <= 1'b0;
                  in_service_q <= 1'b1;
               end
            end
            SERVICE: begin
               if (rti) begin
                  state_q      <= IDLE;
                  in_service_q <= 1'b0;
               end
            end
            default: begin
               state_q      <= IDLE;
               int_req_q    <= 1'b0;
               in_service_q <= 1'b0;
            end
         endcase
      end
   end

   assign int_req    = int_req_q;
   assign vec_addr   = vec_addr_q;
   assign active_ch  = active_ch_q;
   assign in_service = in_service_q;
   assign int_en     = int_en_q;
   assign pending    = pending_q;

endmodule
`default_nettype wire

// File: tb/tb_cu_intr_ctrl.sv
`default_nettype none
// tb_cu_intr_ctrl: directed scenarios plus randomized traffic checked against a behavioural model.
module tb_cu_intr_ctrl;

   localparam logic [7:0] VEC_BASE = 8'h01;

   logic       clk;
   logic       rst;
   logic [3:0] irq;
   logic       mask_we;
   logic [3:0] mask_wdata;
   logic       ie_set;
   logic       ie_clr;
   logic       rti;
   logic       stall_in;
   logic       int_ack;
   logic       int_req;
   logic [7:0] vec_addr;
   logic [1:0] active_ch;
   logic       in_service;
   logic       int_en;
   logic [3:0] pending;

   int n_chk = 0;
   int n_err = 0;

   bit       m_req;
   bit       m_svc;
   bit       m_en;
   bit [3:0] m_pend;
   bit [3:0] m_mask;
   bit [3:0] m_prev;
   bit [1:0] m_ch;
   bit [7:0] m_vec;

   cu_intr_ctrl #(
      .NUM_CH   (4),
      .VEC_W    (8),
      .VEC_BASE (VEC_BASE)
   ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .irq        (irq),
      .mask_we    (mask_we),
      .mask_wdata (mask_wdata),
      .ie_set     (ie_set),
      .ie_clr     (ie_clr),
      .rti        (rti),
      .stall_in   (stall_in),
      .int_ack    (int_ack),
      .int_req    (int_req),
      .vec_addr   (vec_addr),
      .active_ch  (active_ch),
      .in_service (in_service),
      .int_en     (int_en),
      .pending    (pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_req  = 1'b0;
      m_svc  = 1'b0;
      m_en   = 1'b0;
      m_pend = '0;
      m_mask = 4'hF;
      m_prev = '0;
      m_ch   = '0;
      m_vec  = '0;
   endtask

   // One clock edge of the controller's rules, applied to the inputs seen at that edge.
   task automatic model_step();
      bit [3:0] rise, cand, clr, tmp;
      bit       nen;
      int       idx;
      if (!rst) begin
         model_reset();
         return;
      end
      rise = irq & ~m_prev;
      cand = m_pend & m_mask;
      clr  = '0;
      nen  = m_en;
      if (ie_set || (m_svc && rti)) nen = 1'b1;
      if (ie_clr || (m_req && int_ack)) nen = 1'b0;
      if (m_req) begin
         if (int_ack) begin
            clr   = 4'b0001 << m_ch;
            m_req = 1'b0;
            m_svc = 1'b1;
         end
      end else if (m_svc) begin
         if (rti) m_svc = 1'b0;
      end else if (m_en && cand != 0 && !stall_in) begin
         tmp = cand;
         idx = 0;
         while (!tmp[0]) begin
            tmp = tmp >> 1;
            idx++;
         end
         m_req = 1'b1;
         m_ch  = 2'(idx);
         m_vec = VEC_BASE + 8'(idx);
      end
      m_pend = (m_pend & ~clr) | rise;
      if (mask_we) m_mask = mask_wdata;
      m_prev = irq;
      m_en   = nen;
   endtask

   task automatic compare_all();
      check("m_int_req", int_req, m_req);
      check("m_in_service", in_service, m_svc);
      check("m_int_en", int_en, m_en);
      check("m_pending", pending, m_pend);
      check("m_active_ch", active_ch, m_ch);
      check("m_vec_addr", vec_addr, m_vec);
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      compare_all();
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_int_req"}, int_req, 0);
      check({tag, "_vec_addr"}, vec_addr, 0);
      check({tag, "_active_ch"}, active_ch, 0);
      check({tag, "_in_service"}, in_service, 0);
      check({tag, "_int_en"}, int_en, 0);
      check({tag, "_pending"}, pending, 0);
   endtask

   initial begin
      rst = 1'b0; irq = '0; mask_we = 1'b0; mask_wdata = '0;
      ie_set = 1'b0; ie_clr = 1'b0; rti = 1'b0; stall_in = 1'b0; int_ack = 1'b0;
      model_reset();
      tick();
      tick();
      check_reset_vals("rst");
      rst = 1'b1;

      // Held level gives one request only
      ie_set = 1'b1; tick(); ie_set = 1'b0;
      check("s1_en", int_en, 1);
      irq = 4'b0100; tick();
      check("s1_pend", pending, 4'b0100);
      check("s1_noreq_yet", int_req, 0);
      tick();
      check("s1_req", int_req, 1);
      check("s1_vec", vec_addr, 8'h03);
      check("s1_ch", active_ch, 2);
      int_ack = 1'b1; tick(); int_ack = 1'b0;
      check("s1_svc", in_service, 1);
      check("s1_pend_clr", pending, 0);
      tick(); tick();
      check("s1_no_reedge", pending, 0);
      irq = '0; rti = 1'b1; tick(); rti = 1'b0;
      check("s1_en_back", int_en, 1);
      tick();
      check("s1_idle", int_req, 0);

      // Priority between two simultaneous edges
      irq = 4'b1010; tick();
      check("s2_pend", pending, 4'b1010);
      tick();
      check("s2_req", int_req, 1);
      check("s2_vec", vec_addr, 8'h02);
      check("s2_ch", active_ch, 1);
      int_ack = 1'b1; tick(); int_ack = 1'b0;
      check("s2_pend_ack", pending, 4'b1000);
      check("s2_en_ack", int_en, 0);
      check("s2_svc", in_service, 1);
      check("s2_req_drop", int_req, 0);
      irq = '0; rti = 1'b1; tick(); rti = 1'b0;
      check("s2_rti_svc", in_service, 0);
      check("s2_rti_en", int_en, 1);
      tick();
      check("s2_req3", int_req, 1);
      check("s2_vec3", vec_addr, 8'h04);
      check("s2_ch3", active_ch, 3);
      int_ack = 1'b1; tick(); int_ack = 1'b0;
      rti = 1'b1; tick(); rti = 1'b0;

      // Grant frozen in REQ
      irq = 4'b0100; tick(); tick();
      check("s3_req", int_req, 1);
      check("s3_ch", active_ch, 2);
      irq = 4'b0101; stall_in = 1'b1; tick();
      check("s3_ch_hold", active_ch, 2);
      check("s3_req_hold", int_req, 1);
      check("s3_pend", pending, 4'b0101);
      tick();
      check("s3_ch_hold2", active_ch, 2);
      stall_in = 1'b0; irq = '0; int_ack = 1'b1; tick(); int_ack = 1'b0;
      check("s3_pend_wait", pending, 4'b0001);

      // Mask blocks arbitration but not latching
      mask_we = 1'b1; mask_wdata = 4'b1110; tick(); mask_we = 1'b0;
      rti = 1'b1; tick(); rti = 1'b0;
      tick(); tick();
      check("s4_masked", int_req, 0);
      check("s4_pend_kept", pending, 4'b0001);
      mask_we = 1'b1; mask_wdata = 4'b1111; tick(); mask_we = 1'b0;
      check("s4_not_yet", int_req, 0);
      tick();
      check("s4_req", int_req, 1);
      check("s4_vec", vec_addr, 8'h01);
      check("s4_ch", active_ch, 0);
      int_ack = 1'b1; tick(); int_ack = 1'b0;
      rti = 1'b1; tick(); rti = 1'b0;

      // Set-wins and enable priority corners
      irq = 4'b0010; tick(); tick();
      check("s5_ch", active_ch, 1);
      irq = '0; tick();
      irq = 4'b0010; int_ack = 1'b1; ie_set = 1'b1; tick(); int_ack = 1'b0; ie_set = 1'b0;
      check("s5_pend_set_wins", pending, 4'b0010);
      check("s5_ack_over_set", int_en, 0);
      check("s5_svc", in_service, 1);
      ie_set = 1'b1; ie_clr = 1'b1; tick(); ie_set = 1'b0; ie_clr = 1'b0;
      check("s5_clr_wins", int_en, 0);
      rti = 1'b1; ie_clr = 1'b1; tick(); rti = 1'b0; ie_clr = 1'b0;
      check("s5_rti_clr_en", int_en, 0);
      check("s5_rti_clr_svc", in_service, 0);
      tick();
      check("s5_disabled", int_req, 0);
      ie_set = 1'b1; tick(); ie_set = 1'b0;
      tick();
      check("s5_req", int_req, 1);
      ie_clr = 1'b1; tick(); ie_clr = 1'b0;
      check("s5_req_kept", int_req, 1);
      check("s5_en_clr", int_en, 0);
      int_ack = 1'b1; tick(); int_ack = 1'b0;

      // Asynchronous reset in SERVICE
      irq = 4'b1010; tick();
      check("s6_pend_pre", pending, 4'b1000);
      check("s6_svc_pre", in_service, 1);
      rst = 1'b0; irq = '0; #1;
      model_reset();
      check_reset_vals("s6_async");
      tick();
      rst = 1'b1;
      tick();
      check_reset_vals("s6_release");
      ie_set = 1'b1; irq = 4'b0001; tick(); ie_set = 1'b0;
      tick();
      check("s6_req_after", int_req, 1);
      check("s6_vec_after", vec_addr, 8'h01);
      irq = '0;

      // Randomized traffic
      for (int c = 0; c < 1500; c++) begin
         for (int b = 0; b < 4; b++)
            if ($urandom_range(0, 5) == 0) irq[b] = ~irq[b];
         int_ack  = ($urandom_range(0, 2) == 0);
         rti      = ($urandom_range(0, 3) == 0);
         stall_in = ($urandom_range(0, 4) == 0);
         ie_set   = ($urandom_range(0, 7) == 0);
         ie_clr   = ($urandom_range(0, 19) == 0);
         mask_we  = ($urandom_range(0, 15) == 0);
         mask_wdata = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 299) == 0) begin
            rst = 1'b0; #1;
            model_reset();
            compare_all();
            rst = 1'b1;
         end
         tick();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
